// File: rtl/reg_bank_arb_pkg.sv
// reg_bank_arb_pkg
// Shared definitions for the register-bank arbiter and its round-robin
// sub-arbiter:
//   - state_t      : sequencer FSM encoding (IDLE, ACCESS, RESP)
//   - REQ_HOST/CORE: requester ids, also the bit index in the 2-bit buses
//   - LOCK_BIT     : bit of the lock register that holds the lock flag
//   - lock_reg_idx : index of the lock register, always the last register
package reg_bank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int REQ_HOST = 0;
  localparam int REQ_CORE = 1;

  localparam int LOCK_BIT = 0;

  function automatic int lock_reg_idx(input int nreg);
    return nreg - 1;
  endfunction

endpackage

// File: rtl/reg_bank_arb_rr_arb.sv
// reg_bank_rr_arb
// Two-input round-robin arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   valid[1:0] : request lines (bit0 host, bit1 core)
//   advance    : pulse when the current grant is accepted; updates last_grant
//   grant[1:0] : combinational one-hot grant, never both bits set
// last_grant resets to the core so that the host wins the first tie.
module reg_bank_rr_arb
  import reg_bank_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_reg;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (advance) begin
      last_grant_reg <= grant[REQ_CORE];
    end
  end

endmodule

// File: rtl/reg_bank_arb.sv
// reg_bank_arb
// Arbiter and sequencer for a bank of NREG 8-bit configuration registers
// shared by a host requester (0) and a core requester (1). Each transaction
// takes three cycles: IDLE (handshake), ACCESS (register read/write),
// RESP (one-cycle response strobe to the granted requester).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid[1:0], req_ready[1:0], req_wr[1:0] : per-requester handshake
//   req_addr[2*AW-1:0]  : slice k = address of requester k
//   req_wdata[15:0]     : slice k = write data of requester k
//   rsp_valid[1:0], rsp_rdata[7:0], rsp_err : registered response
//   reg_q[NREG*8-1:0]   : live contents of the whole bank
// Optional build macro REG_LOCK_EN: the last register becomes a lock
// register; while its bit0 is set, core writes to any other register are
// dropped and answered with rsp_err.
module reg_bank_arb
  import reg_bank_arb_pkg::*;
#(
  parameter int                NREG    = 16,
  parameter int                AW      = 4,
  parameter logic [NREG*8-1:0] INI_VEC = {NREG{8'h00}},
  parameter int                DLY     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_wr,
  input  logic [2*AW-1:0]    req_addr,
  input  logic [15:0]        req_wdata,
  output logic [1:0]         rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic               rsp_err,
  output logic [NREG*8-1:0]  reg_q
);

  // DLY only matters for delay-annotated simulation models; this RTL is
  // zero-delay, so DLY appears only in this configuration sanity guard.
  // An illegal configuration elaborates an empty marker block.
  if (DLY < 0 || (2 ** AW) < NREG) begin : g_bad_cfg
  end

  state_t          state_reg;
  logic [1:0]      grant;
  logic            advance;
  logic            sel;
  logic            wr_reg;
  logic [AW-1:0]   addr_reg;
  logic [7:0]      wdata_reg;
  logic            id_reg;
  logic [7:0]      bank [NREG];
  logic [NREG-1:0] wen;
  logic            in_range;
  logic            blocked;
  logic [7:0]      rd_data;

  reg_bank_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (advance),
    .grant   (grant)
  );

  // Ready is only offered while idle; the grant is already one-hot.
  assign req_ready = (state_reg == IDLE) ? grant : 2'b00;
  assign advance   = |(req_valid & req_ready);
  assign sel       = grant[REQ_CORE];

  assign in_range = (32'(addr_reg) < NREG);

`ifdef REG_LOCK_EN
  localparam int LOCK_IDX = lock_reg_idx(NREG);
  // The lock register itself stays writable so the core cannot lock itself out.
  assign blocked = wr_reg && (id_reg == 1'(REQ_CORE)) &&
                   bank[LOCK_IDX][LOCK_BIT] && (32'(addr_reg) != LOCK_IDX);
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      if (32'(addr_reg) == i) rd_data = bank[i];
    end
  end

  // Register bank: one write-enabled byte per address.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    assign wen[gi] = (state_reg == ACCESS) && wr_reg && !blocked &&
                     (32'(addr_reg) == gi);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bank[gi] <= INI_VEC[gi*8 +: 8];
      end else if (wen[gi]) begin
        bank[gi] <= wdata_reg;
      end
    end

    assign reg_q[gi*8 +: 8] = bank[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 8'h00;
      id_reg    <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (advance) begin
            id_reg    <= sel;
            wr_reg    <= req_wr[sel];
            addr_reg  <= sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
            wdata_reg <= sel ? req_wdata[15:8] : req_wdata[7:0];
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          // Response is staged here so that it appears registered in RESP.
          rsp_valid <= id_reg ? 2'b10 : 2'b01;
          rsp_rdata <= (in_range && !wr_reg) ? rd_data : 8'h00;
          rsp_err   <= !in_range || blocked;
          state_reg <= RESP;
        end
        RESP: begin
          rsp_valid <= 2'b00;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arb.sv
// tb_reg_bank_arb
// Self-checking bench for reg_bank_arb: directed scenarios followed by
// random two-requester traffic, checked against a transaction-level model
// (register array, last-served requester, pending request per requester).
module tb_reg_bank_arb;

  localparam int NREG = 12;
  localparam int AW   = 4;

  function automatic logic [NREG*8-1:0] mk_ini();
    logic [NREG*8-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*8 +: 8] = 8'(16 + 7 * i);
    v[31:24] = 8'hA5;
    return v;
  endfunction

  localparam logic [NREG*8-1:0] INI = mk_ini();

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_wr;
  logic [2*AW-1:0]   req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic [NREG*8-1:0] reg_q;

  reg_bank_arb #(
    .NREG    (NREG),
    .AW      (AW),
    .INI_VEC (INI),
    .DLY     (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .reg_q     (reg_q)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_bank [NREG];
  int         m_last;
  bit         p_v    [2];
  bit         p_wr   [2];
  int         p_addr [2];
  logic [7:0] p_wd   [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic check_val(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [NREG*8-1:0] model_flat();
    logic [NREG*8-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*8 +: 8] = m_bank[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_bank[i] = INI[i*8 +: 8];
    m_last = 1;
    for (int k = 0; k < 2; k++) p_v[k] = 1'b0;
  endtask

  task automatic drive_pins();
    req_valid = {p_v[1], p_v[0]};
    req_wr    = {p_wr[1], p_wr[0]};
    req_addr  = {AW'(p_addr[1]), AW'(p_addr[0])};
    req_wdata = {p_wd[1], p_wd[0]};
  endtask

  task automatic set_req(input int k, input bit wr, input int addr,
                         input logic [7:0] wd);
    p_v[k] = 1'b1; p_wr[k] = wr; p_addr[k] = addr; p_wd[k] = wd;
  endtask

  // Called just after a rising edge with the DUT idle and at least one
  // request pending; returns just after the rising edge that re-enters IDLE.
  task automatic serve_one();
    int         w;
    bit         oor;
    bit         blk;
    bit         exp_err;
    logic [7:0] exp_rd;
    if (p_v[0] && p_v[1]) w = (m_last == 1) ? 0 : 1;
    else if (p_v[0])      w = 0;
    else                  w = 1;
    drive_pins();
    @(negedge clk);
    check_val("req_ready", req_ready, (w == 0) ? 2'b01 : 2'b10);

    oor = (p_addr[w] >= NREG);
    blk = 1'b0;
`ifdef REG_LOCK_EN
    blk = p_wr[w] && (w == 1) && m_bank[NREG-1][0] && (p_addr[w] != NREG - 1);
`endif
    exp_err = oor || blk;
    exp_rd  = 8'h00;
    if (!oor && !blk) begin
      if (p_wr[w]) m_bank[p_addr[w]] = p_wd[w];
      else         exp_rd = m_bank[p_addr[w]];
    end
    m_last = w;
    n_txn++;
    $display("txn %0d: req%0d %s addr=%0d wdata=%h -> err=%0d rdata=%h",
             n_txn, w, p_wr[w] ? "wr" : "rd", p_addr[w], p_wd[w], exp_err, exp_rd);

    @(posedge clk); #1;
    p_v[w] = 1'b0;
    drive_pins();
    @(negedge clk);
    check_val("ready_busy", req_ready, 2'b00);
    check_val("rsp_early", rsp_valid, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rsp_valid", rsp_valid, (w == 0) ? 2'b01 : 2'b10);
    check_val("rsp_err", rsp_err, exp_err);
    check_val("rsp_rdata", rsp_rdata, exp_rd);
    check_val("reg_q", reg_q, model_flat());
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      p_wr[k] = 1'b0; p_addr[k] = 0; p_wd[k] = 8'h00;
    end
    model_reset();
    rst_n = 1'b0;
    drive_pins();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_reg_q", reg_q, model_flat());
    check_val("rst_reg3", reg_q[31:24], 8'hA5);
    check_val("rst_rsp_valid", rsp_valid, 2'b00);
    check_val("rst_rsp_rdata", rsp_rdata, 8'h00);
    check_val("rst_rsp_err", rsp_err, 1'b0);
    check_val("rst_ready", req_ready, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nothing requested: ready stays low.
    drive_pins();
    @(negedge clk);
    check_val("idle_ready", req_ready, 2'b00);
    @(posedge clk); #1;

    // Tie right after reset: host first; host re-requests, so core next.
    set_req(0, 1'b0, 3, 8'h00);
    set_req(1, 1'b0, 0, 8'h00);
    serve_one();
    set_req(0, 1'b1, 4, 8'h77);
    serve_one();
    serve_one();

    // Host write then read-back.
    set_req(0, 1'b1, 2, 8'h3C);
    serve_one();
    set_req(0, 1'b0, 2, 8'h00);
    serve_one();

    // Core read out of range.
    set_req(1, 1'b0, NREG, 8'h00);
    serve_one();

    // Reset during ACCESS of a host write.
    set_req(0, 1'b1, 5, 8'hFF);
    drive_pins();
    @(negedge clk);
    check_val("mid_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    drive_pins();
    @(negedge clk);
    check_val("mid_rst_rsp", rsp_valid, 2'b00);
    check_val("mid_rst_reg_q", reg_q, model_flat());
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_rsp2", rsp_valid, 2'b00);
    check_val("mid_rst_reg5", reg_q[47:40], INI[47:40]);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie after the aborted transaction: host wins again.
    set_req(0, 1'b0, 5, 8'h00);
    set_req(1, 1'b0, 1, 8'h00);
    serve_one();
    serve_one();

`ifdef REG_LOCK_EN
    set_req(0, 1'b1, NREG - 1, 8'h01);
    serve_one();
    set_req(1, 1'b1, 0, 8'h11);
    serve_one();
    check_val("lock_err", rsp_err, 1'b1);
    set_req(0, 1'b1, 0, 8'h11);
    serve_one();
    check_val("lock_host_wr", reg_q[7:0], 8'h11);
    set_req(0, 1'b1, NREG - 1, 8'h00);
    serve_one();
`endif

    // Random two-requester traffic; losers keep their request pending.
    for (int n = 0; n < 80; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_v[k] && $urandom_range(0, 3) != 0)
          set_req(k, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                  8'($urandom));
      end
      if (!p_v[0] && !p_v[1])
        set_req(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 8'($urandom));
      serve_one();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_arb.md
Name: reg_bank_arb

Overview:
Two-port arbiter and sequencer for a bank of NREG 8-bit write-enabled configuration registers.
- Requester 0 is the host interface and requester 1 is the internal core; both share the bank.
- It serialises their read/write transactions through a round-robin arbiter and a 3-state FSM.
- It returns a one-cycle response to the granted requester.
- The full bank contents are exported flat for downstream datapath configuration.

Parameters:
NREG, 16, number of 8-bit registers in the bank
AW, 4, address width; must satisfy 2**AW >= NREG
INI_VEC, {NREG{8'h00}}, NREG*8-bit reset image; register i resets to INI_VEC[8i+7:8i]
DLY, 1, delay applied to sequential assignments (simulation only)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  2  per-requester request valid (bit0 host, bit1 core)
req_ready  out  2  per-requester accept; the transaction transfers when valid&ready
req_wr  in  2  per-requester 1 = write, 0 = read
req_addr  in  2*AW  per-requester register address, slice k = requester k
req_wdata  in  16  per-requester write data, slice k = requester k
rsp_valid  out  2  one-cycle response strobe to the requester that was granted
rsp_rdata  out  8  read data; valid while any rsp_valid bit is set
rsp_err  out  1  address out of range (addr >= NREG); valid with rsp_valid
reg_q  out  NREG*8  current contents of all registers, flat

Behaviour:
- Reset values: FSM=IDLE, last_grant=1 (host wins first), req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, reg_q=INI_VEC.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one req_valid bit is set, that requester wins.
  - If both are set, the requester != last_grant wins.
  - req_ready[winner] is asserted combinationally and is never set for both.
  - On valid&ready: latch wr/addr/wdata/id, update last_grant, go to ACCESS.
  - If no valid bit is set: stay in IDLE, req_ready=0.
- ACCESS (one cycle):
  - Write in range: wen for register addr asserted this cycle; the register updates at the closing edge.
  - Read in range: register addr is captured into rsp_rdata at the closing edge.
  - Addr >= NREG: no register changes, rsp_rdata<=8'h00, rsp_err<=1.
  - Writes return rsp_rdata=8'h00.
  - Go to RESP.
- RESP (one cycle): rsp_valid[id]=1, then go to IDLE. rsp_valid, rsp_rdata and rsp_err are registered.
- Latency: handshake in cycle T, rsp_valid in cycle T+2, written value on reg_q in cycle T+2. Throughput: one transaction per 3 cycles.
- Requesters hold valid, wr, addr and wdata stable until ready. Dropping valid before ready is legal and withdraws the request.
- A loser's pending request is served next; starvation is impossible.
- Only the arbiter writes the registers, so same-address contention cannot occur. Transactions complete in grant order.
- reg_q reflects register state at all times, with no extra pipeline stage.
- Reset asserted mid-transaction: the FSM aborts to IDLE immediately, no rsp_valid is emitted, and all registers return to INI_VEC.

Optional Feature:
REG_LOCK_EN.
- Defined:
  - Register NREG-1 is the lock register, and bit0 = lock.
  - While lock=1, core (requester 1) writes to any address other than NREG-1 are dropped and answered with rsp_err=1. Core reads are unaffected.
  - Host writes are never blocked. The lock register itself stays writable by both requesters.
- Undefined: no lock logic; register NREG-1 is an ordinary register.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Requester id constants: REQ_HOST=0, REQ_CORE=1.
  - Lock register index and lock bit position.
- Natural sub-module: reg_bank_rr_arb, a 2-input round-robin arbiter with last_grant state, grant output and an advance input.
- The register array is a generate loop of 8-bit write-enabled registers with async reset to INI_VEC slices.

Test Plan:
- Reset with INI_VEC reg3=8'hA5: after reset reg_q[31:24]=8'hA5, all outputs 0, FSM in IDLE.
- Host write addr 2 data 8'h3C: req_ready[0] in T; reg_q[23:16]=8'h3C and rsp_valid=2'b01 in T+2; host read addr 2 gives rsp_rdata=8'h3C.
- Both requesters valid in the same cycle after reset: host granted first, core granted in the next IDLE; a repeat with both valid grants core first.
- Core read addr NREG (out of range): rsp_valid=2'b10, rsp_err=1, rsp_rdata=8'h00, reg_q unchanged.
- Reset pulsed during ACCESS of a write 8'hFF to addr 5: no rsp_valid; reg5 = INI value after reset.
- REG_LOCK_EN defined: host writes lock=1; core write 8'h11 to addr 0 gives rsp_err=1 with reg0 unchanged; the same write from host succeeds.
